// File: rtl/auv_wb_sram_slave.sv
// Wishbone B4 pipelined slave fronting a 16-bit byte-lane SRAM window.
// Holds one request at a time, with an optional fixed wait-state delay before the response.
module auv_wb_sram_slave #(
  parameter int                    ADDR_WIDTH  = 24,
  parameter int                    MEM_WORDS   = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [15:0]           wb_dat_i,
  output logic [15:0]           wb_dat_o,
  input  logic [1:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o
);

  localparam int                  LP_WW       = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] LP_SPAN     = (ADDR_WIDTH+1)'(2 * MEM_WORDS);
  localparam logic [3:0]          LP_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic                LP_NO_WAIT  = (WAIT_STATES == 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;

  logic             r_we;
  logic             r_rng;
  logic [1:0]       r_sel;
  logic [15:0]      r_wdat;
  logic [LP_WW-1:0] r_word;

  logic [15:0]      r_dat_o;
  logic             r_ack;
  logic             r_err;

  logic [15:0]      r_mem [MEM_WORDS];

  logic [ADDR_WIDTH:0] w_diff;
  logic                w_rng;
  logic [LP_WW-1:0]    w_word;
  logic                w_stall;
  logic                w_accept;
  logic                w_direct;
  logic                w_from_wait;
  logic                w_go_resp;
  logic                w_a_we;
  logic                w_a_rng;
  logic [1:0]          w_a_sel;
  logic [15:0]         w_a_dat;
  logic [LP_WW-1:0]    w_a_word;
  logic                w_mem_wr;

  // One extra bit keeps the borrow: an address below the base wraps above
  // 2^ADDR_WIDTH and so fails the single span compare.
  assign w_diff = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
  assign w_rng  = (w_diff < LP_SPAN);
  assign w_word = w_diff[LP_WW:1];

  assign w_stall     = (r_state == S_WAIT);
  assign w_accept    = wb_cyc_i & wb_stb_i & ~w_stall;
  assign w_direct    = w_accept & LP_NO_WAIT;
  assign w_from_wait = (r_state == S_WAIT) & wb_cyc_i & (r_cnt == 4'd0);
  assign w_go_resp   = w_direct | w_from_wait;

  // Zero-wait requests hit the array straight from the bus; delayed ones use the latched copy.
  assign w_a_we   = w_direct ? wb_we_i  : r_we;
  assign w_a_rng  = w_direct ? w_rng    : r_rng;
  assign w_a_sel  = w_direct ? wb_sel_i : r_sel;
  assign w_a_dat  = w_direct ? wb_dat_i : r_wdat;
  assign w_a_word = w_direct ? w_word   : r_word;
  assign w_mem_wr = w_go_resp & w_a_we & w_a_rng & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (!wb_cyc_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          if (w_accept) begin
            r_state <= LP_NO_WAIT ? S_RESP : S_WAIT;
            r_cnt   <= LP_CNT_INIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we   <= wb_we_i;
      r_rng  <= w_rng;
      r_sel  <= wb_sel_i;
      r_wdat <= wb_dat_i;
      r_word <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= 16'h0000;
    end else begin
      r_ack   <= w_go_resp & w_a_rng;
      r_err   <= w_go_resp & ~w_a_rng;
      r_dat_o <= (w_go_resp & w_a_rng & ~w_a_we) ? r_mem[w_a_word] : 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      if (w_a_sel[0]) r_mem[w_a_word][7:0]  <= w_a_dat[7:0];
      if (w_a_sel[1]) r_mem[w_a_word][15:8] <= w_a_dat[15:8];
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_err_o   = r_err;
  assign wb_dat_o   = r_dat_o;
  assign wb_stall_o = w_stall;

endmodule

// File: tb/tb_auv_wb_sram_slave.sv
// Bench for auv_wb_sram_slave: a zero-wait 4096-word instance at base 0 and a
// three-wait 64-word instance at base 0x1000, both checked against array models.
module tb_auv_wb_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [23:0] a_adr;  logic [15:0] a_wdat, a_rdat;  logic [1:0] a_sel;
  logic a_we, a_stb, a_cyc, a_ack, a_err, a_stall;
  logic [23:0] b_adr;  logic [15:0] b_wdat, b_rdat;  logic [1:0] b_sel;
  logic b_we, b_stb, b_cyc, b_ack, b_err, b_stall;

  int total = 0;
  int bad   = 0;

  logic [15:0] ma [4096];
  logic [15:0] mb [64];

  auv_wb_sram_slave #(.ADDR_WIDTH(24), .MEM_WORDS(4096), .BASE_ADDR(24'h0), .WAIT_STATES(0)) u_a (
    .clk(clk), .rst(rst), .wb_adr_i(a_adr), .wb_dat_i(a_wdat), .wb_dat_o(a_rdat),
    .wb_sel_i(a_sel), .wb_we_i(a_we), .wb_stb_i(a_stb), .wb_cyc_i(a_cyc),
    .wb_ack_o(a_ack), .wb_err_o(a_err), .wb_stall_o(a_stall));

  auv_wb_sram_slave #(.ADDR_WIDTH(24), .MEM_WORDS(64), .BASE_ADDR(24'h1000), .WAIT_STATES(3)) u_b (
    .clk(clk), .rst(rst), .wb_adr_i(b_adr), .wb_dat_i(b_wdat), .wb_dat_o(b_rdat),
    .wb_sel_i(b_sel), .wb_we_i(b_we), .wb_stb_i(b_stb), .wb_cyc_i(b_cyc),
    .wb_ack_o(b_ack), .wb_err_o(b_err), .wb_stall_o(b_stall));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One zero-wait bus cycle: request driven now, response expected in the next cycle.
  task automatic a_cycle(input logic stb, input logic we, input logic [23:0] adr,
                         input logic [1:0] sel, input logic [15:0] dat,
                         input string nm, output logic [15:0] rd);
    logic e_ack, e_err, chk_dat;
    logic [15:0] e_dat;
    int w;
    e_ack = 1'b0; e_err = 1'b0; e_dat = 16'h0; chk_dat = 1'b1;
    if (stb) begin
      if (adr < 24'h2000) begin
        e_ack = 1'b1;
        w = int'(adr >> 1);
        if (we) begin
          chk_dat = 1'b0;
          if (sel[0]) ma[w][7:0]  = dat[7:0];
          if (sel[1]) ma[w][15:8] = dat[15:8];
        end else begin
          e_dat = ma[w];
        end
      end else begin
        e_err = 1'b1;
      end
    end
    a_cyc = 1'b1; a_stb = stb; a_we = we; a_adr = adr; a_sel = sel; a_wdat = dat;
    step();
    a_stb = 1'b0;
    total++; if (a_ack !== e_ack) begin bad++; $display("FAIL %s ack: got %b want %b", nm, a_ack, e_ack); end
    total++; if (a_err !== e_err) begin bad++; $display("FAIL %s err: got %b want %b", nm, a_err, e_err); end
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL %s stall: got %b want 0", nm, a_stall); end
    if (chk_dat) begin
      total++; if (a_rdat !== e_dat) begin bad++; $display("FAIL %s dat: got %h want %h", nm, a_rdat, e_dat); end
    end
    rd = a_rdat;
  endtask

  // One three-wait transaction from idle: stall for three cycles, response in the fourth.
  task automatic b_xact(input logic we, input logic [23:0] adr, input logic [1:0] sel,
                        input logic [15:0] dat, input string nm, output logic [15:0] rd);
    logic e_ack, e_err, chk_dat;
    logic [15:0] e_dat;
    int w;
    e_ack = 1'b0; e_err = 1'b0; e_dat = 16'h0; chk_dat = 1'b1;
    if (adr >= 24'h1000 && adr < 24'h1080) begin
      e_ack = 1'b1;
      w = int'((adr - 24'h1000) >> 1);
      if (we) begin
        chk_dat = 1'b0;
        if (sel[0]) mb[w][7:0]  = dat[7:0];
        if (sel[1]) mb[w][15:8] = dat[15:8];
      end else begin
        e_dat = mb[w];
      end
    end else begin
      e_err = 1'b1;
    end
    b_cyc = 1'b1; b_stb = 1'b1; b_we = we; b_adr = adr; b_sel = sel; b_wdat = dat;
    step();
    b_stb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++; if (b_stall !== 1'b1) begin bad++; $display("FAIL %s wait%0d stall: got %b want 1", nm, k, b_stall); end
      total++; if ((b_ack | b_err) !== 1'b0) begin bad++; $display("FAIL %s wait%0d early resp: got %b want 0", nm, k, b_ack | b_err); end
      step();
    end
    total++; if (b_ack !== e_ack) begin bad++; $display("FAIL %s ack: got %b want %b", nm, b_ack, e_ack); end
    total++; if (b_err !== e_err) begin bad++; $display("FAIL %s err: got %b want %b", nm, b_err, e_err); end
    total++; if (b_stall !== 1'b0) begin bad++; $display("FAIL %s resp stall: got %b want 0", nm, b_stall); end
    if (chk_dat) begin
      total++; if (b_rdat !== e_dat) begin bad++; $display("FAIL %s dat: got %h want %h", nm, b_rdat, e_dat); end
    end
    rd = b_rdat;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0; a_adr = '0; a_sel = '0; a_wdat = '0;
    b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_adr = '0; b_sel = '0; b_wdat = '0;
    step(); step();
    total++; if ({a_ack, a_err, a_stall, a_rdat} !== 19'h0) begin bad++; $display("FAIL reset_a: got %h want 0", {a_ack, a_err, a_stall, a_rdat}); end
    total++; if ({b_ack, b_err, b_stall, b_rdat} !== 19'h0) begin bad++; $display("FAIL reset_b: got %h want 0", {b_ack, b_err, b_stall, b_rdat}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_init();
    logic [15:0] rd;
    for (int w = 0; w < 40; w++)
      a_cycle(1'b1, 1'b1, 24'(w * 2), 2'b11, 16'($urandom), "init_a", rd);
    a_cycle(1'b1, 1'b1, 24'h1FFE, 2'b11, 16'($urandom), "init_a_top", rd);
    a_cycle(1'b0, 1'b0, 24'h0, 2'b00, 16'h0, "init_a_idle", rd);
    for (int w = 0; w < 64; w++)
      b_xact(1'b1, 24'h1000 + 24'(w * 2), 2'b11, 16'($urandom), "init_b", rd);
  endtask

  task automatic test_ws0_basic();
    logic [15:0] rd;
    a_cycle(1'b1, 1'b1, 24'h000010, 2'b11, 16'hBEEF, "ws0_wr", rd);
    a_cycle(1'b1, 1'b0, 24'h000010, 2'b11, 16'h0000, "ws0_rd", rd);
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL ws0_beef: got %h want beef", rd); end
    a_cycle(1'b0, 1'b0, 24'h0, 2'b00, 16'h0, "ws0_idle", rd);
  endtask

  task automatic test_byte_lanes();
    logic [15:0] rd;
    a_cycle(1'b1, 1'b1, 24'h000010, 2'b11, 16'h1234, "lane_init", rd);
    a_cycle(1'b1, 1'b1, 24'h000010, 2'b10, 16'hAB00, "lane_hi", rd);
    a_cycle(1'b1, 1'b1, 24'h000011, 2'b01, 16'h00CD, "lane_lo", rd);
    a_cycle(1'b1, 1'b0, 24'h000010, 2'b00, 16'h0000, "lane_rd", rd);
    total++; if (rd !== 16'hABCD) begin bad++; $display("FAIL lanes_abcd: got %h want abcd", rd); end
    a_cycle(1'b1, 1'b1, 24'h000010, 2'b00, 16'hFFFF, "lane_sel0", rd);
    a_cycle(1'b1, 1'b0, 24'h000010, 2'b11, 16'h0000, "lane_rd2", rd);
    total++; if (rd !== 16'hABCD) begin bad++; $display("FAIL lanes_sel0: got %h want abcd", rd); end
  endtask

  task automatic test_range_a();
    logic [15:0] rd;
    a_cycle(1'b1, 1'b1, 24'h000000, 2'b11, 16'h5A5A, "rng_w0", rd);
    a_cycle(1'b1, 1'b0, 24'h002000, 2'b11, 16'h0000, "rng_rd_oob", rd);
    a_cycle(1'b1, 1'b1, 24'h002000, 2'b11, 16'hFFFF, "rng_wr_oob", rd);
    a_cycle(1'b1, 1'b0, 24'h000000, 2'b11, 16'h0000, "rng_rd0", rd);
    total++; if (rd !== 16'h5A5A) begin bad++; $display("FAIL range_unchanged: got %h want 5a5a", rd); end
    a_cycle(1'b1, 1'b0, 24'h001FFE, 2'b11, 16'h0000, "rng_top", rd);
    a_cycle(1'b1, 1'b0, 24'hFFFFFE, 2'b11, 16'h0000, "rng_far", rd);
  endtask

  task automatic test_pair();
    logic [15:0] rd, lo, hi;
    lo = 16'($urandom); hi = 16'($urandom);
    a_cycle(1'b1, 1'b1, 24'h000040, 2'b11, lo, "pair_wlo", rd);
    a_cycle(1'b1, 1'b1, 24'h000042, 2'b11, hi, "pair_whi", rd);
    a_cycle(1'b1, 1'b0, 24'h000040, 2'b11, 16'h0, "pair_rlo", rd);
    total++; if (rd !== lo) begin bad++; $display("FAIL pair_lo: got %h want %h", rd, lo); end
    a_cycle(1'b1, 1'b0, 24'h000042, 2'b11, 16'h0, "pair_rhi", rd);
    total++; if (rd !== hi) begin bad++; $display("FAIL pair_hi: got %h want %h", rd, hi); end
  endtask

  task automatic test_random_a();
    logic [15:0] rd;
    logic [23:0] adr;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) adr = 24'($urandom_range(32'h2000, 32'hFFFFFF));
      else adr = 24'($urandom_range(0, 39) * 2 + $urandom_range(0, 1));
      a_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), adr, 2'($urandom),
              16'($urandom), "rand_a", rd);
    end
  endtask

  task automatic test_ws3();
    logic [15:0] rd;
    b_xact(1'b0, 24'h100C, 2'b11, 16'h0, "ws3_single", rd);
    // Second request is held on the bus from T+1 while the first is stalled.
    b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b0; b_adr = 24'h1010; b_sel = 2'b11;
    step();
    b_adr = 24'h1020;
    for (int k = 0; k < 3; k++) begin
      total++; if ({b_stall, b_ack} !== 2'b10) begin bad++; $display("FAIL ws3_held1_t%0d: got %b want 10", k + 1, {b_stall, b_ack}); end
      step();
    end
    total++; if ({b_ack, b_stall} !== 2'b10) begin bad++; $display("FAIL ws3_ack1: got %b want 10", {b_ack, b_stall}); end
    total++; if (b_rdat !== mb[8]) begin bad++; $display("FAIL ws3_dat1: got %h want %h", b_rdat, mb[8]); end
    step();
    b_stb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++; if ({b_stall, b_ack} !== 2'b10) begin bad++; $display("FAIL ws3_held2_t%0d: got %b want 10", k + 5, {b_stall, b_ack}); end
      step();
    end
    total++; if ({b_ack, b_err} !== 2'b10) begin bad++; $display("FAIL ws3_ack2: got %b want 10", {b_ack, b_err}); end
    total++; if (b_rdat !== mb[16]) begin bad++; $display("FAIL ws3_dat2: got %h want %h", b_rdat, mb[16]); end
    step();
    total++; if ({b_ack, b_err} !== 2'b00) begin bad++; $display("FAIL ws3_extra: got %b want 00", {b_ack, b_err}); end
  endtask

  task automatic test_range_b();
    logic [15:0] rd;
    b_xact(1'b0, 24'h000FFE, 2'b11, 16'h0, "rngb_below", rd);
    b_xact(1'b0, 24'h001080, 2'b11, 16'h0, "rngb_above", rd);
    b_xact(1'b1, 24'h000FFE, 2'b11, 16'hDEAD, "rngb_wr_below", rd);
    b_xact(1'b0, 24'h00107E, 2'b11, 16'h0, "rngb_top", rd);
  endtask

  task automatic test_abort();
    logic [15:0] rd, old;
    old = mb[5];
    b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_adr = 24'h100A; b_sel = 2'b11; b_wdat = ~old;
    step();
    b_stb = 1'b0;
    step();
    b_cyc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if ({b_ack, b_err, b_stall} !== 3'b000) begin bad++; $display("FAIL abort_t%0d: got %b want 000", k + 3, {b_ack, b_err, b_stall}); end
    end
    b_xact(1'b0, 24'h100A, 2'b11, 16'h0, "abort_rd", rd);
    total++; if (rd !== old) begin bad++; $display("FAIL abort_nowrite: got %h want %h", rd, old); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd, old;
    old = mb[6];
    b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_adr = 24'h100C; b_sel = 2'b11; b_wdat = ~old;
    step();
    b_stb = 1'b0;
    step();
    rst = 1'b1;
    step();
    total++; if ({b_ack, b_err, b_stall, b_rdat} !== 19'h0) begin bad++; $display("FAIL rst_mid_out: got %h want 0", {b_ack, b_err, b_stall, b_rdat}); end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if ({b_ack, b_err} !== 2'b00) begin bad++; $display("FAIL rst_mid_resp%0d: got %b want 00", k, {b_ack, b_err}); end
    end
    b_xact(1'b0, 24'h100C, 2'b11, 16'h0, "rst_mid_rd", rd);
    total++; if (rd !== old) begin bad++; $display("FAIL rst_mid_nowrite: got %h want %h", rd, old); end
  endtask

  task automatic test_random_b();
    logic [15:0] rd;
    logic [23:0] adr;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: adr = 24'($urandom_range(0, 32'h0FFF));
        1: adr = 24'($urandom_range(32'h1080, 32'hFFFFFF));
        default: adr = 24'h1000 + 24'($urandom_range(0, 127));
      endcase
      b_xact(1'($urandom), adr, 2'($urandom), 16'($urandom), "rand_b", rd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init();
    test_ws0_basic();
    test_byte_lanes();
    test_range_a();
    test_pair();
    test_random_a();
    test_ws3();
    test_range_b();
    test_abort();
    test_reset_mid();
    test_random_b();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
